// File: rtl/stall_mem_resp.sv
// Multi-cycle 16-bit word memory responder with Stall/Done/Err handshake (STALL_MEM_RANDOM_EN adds LFSR jitter).
// Latency: request sampled at edge N -> Done during cycle N+LATENCY (plus 0..3 cycles when jitter is enabled, capped at 15).
// Backpressure: Stall is high while a request is in flight; requests seen in BUSY and RESP are dropped, not queued.
module stall_mem_resp #(
  parameter int AW      = 10,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        Err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            op_wr_q, op_wr_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [15:0]     wdat_q, wdat_d;
  logic            err_q, err_d;
  logic [15:0]     dout_q, dout_d;
  logic [4:0]      lat_tot;
  logic            req_ok, req_bad;

  logic [15:0]     mem [2**AW];

  // Address bits above the word index alias onto the array.
  logic            unused_addr_hi;
  assign unused_addr_hi = ^Addr[15:AW+1];

`ifdef STALL_MEM_RANDOM_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [4:0]  lat_sum;

  // Fibonacci LFSR, taps 16,14,13,11, stepping every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR register; reseeding on reset makes the latency sequence repeatable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 16'hACE1;
    else      lfsr_q <= lfsr_d;
  end

  // Total latency for a request accepted this cycle, saturated to the 4-bit counter range.
  always_comb begin
    lat_sum = 5'(LATENCY) + {3'b000, lfsr_q[1:0]};
    lat_tot = (lat_sum > 5'd15) ? 5'd15 : lat_sum;
  end
`else
  // Fixed latency.
  always_comb begin
    lat_tot = 5'(LATENCY);
  end
`endif

  assign req_ok  = (Rd ^ Wr) & ~Addr[0];
  assign req_bad = (Rd & Wr) | ((Rd ^ Wr) & Addr[0]);

  // Next-state, capture and output decode; read data is fetched on the edge entering RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    err_d   = 1'b0;
    dout_d  = 16'h0000;
    Done    = 1'b0;
    Stall   = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = req_bad;
        if (req_ok) begin
          op_wr_d = Wr;
          idx_d   = Addr[AW:1];
          wdat_d  = DataIn;
          if (lat_tot == 5'd1) begin
            state_d = RESP;
            dout_d  = Wr ? 16'h0000 : mem[Addr[AW:1]];
          end else begin
            cnt_d   = 4'(lat_tot - 5'd1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          dout_d  = op_wr_q ? 16'h0000 : mem[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset drops any in-flight request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdat_q  <= 16'h0000;
      err_q   <= 1'b0;
      dout_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Write commits on the edge that ends RESP, so a following read sees it; the array is not reset.
  always_ff @(posedge clk) begin
    if (state_q == RESP && op_wr_q) mem[idx_q] <= wdat_q;
  end

  assign DataOut = dout_q;
  assign Err     = err_q;

endmodule
